// File: rtl/text_pixel_pipe.sv
// text_pixel_pipe: turns VGA timing-generator coordinates into 12-bit RGB for a text screen
// of COLS x ROWS character cells, each 8x16 pixels.
//
// Pipeline (3 pclk from inputs to vga_*/hsync/vsync):
//   S0: char_addr is driven combinationally from h_cnt/v_cnt.
//   S1: char_data returns and font_addr = {char_data, glyph row} is driven.
//   S2: font_data returns, the glyph bit is selected, the cursor is XOR-ed in, and the colour is
//       registered to the outputs.
//
// Ports:
//   pclk, reset            pixel clock; synchronous active-high reset
//   h_cnt, v_cnt           pixel column/line from the timing generator
//   valid_in               active-area flag; pixels with valid_in = 0 are blanked to black
//   hsync_in, vsync_in     active-low syncs, delayed by 3 cycles onto hsync/vsync
//   cursor_col, cursor_row cursor cell, latched on each vsync_in falling edge
//   fg_color, bg_color     {R,G,B} colours, 4 bits per channel
//   char_addr/char_data    text RAM port (1-cycle read latency)
//   font_addr/font_data    font ROM port (1-cycle read latency, MSB = leftmost pixel)
//   vga_r/g/b              registered pixel colour
//
// Optional feature: define TEXT_CURSOR_BLINK_EN to build the frame counter that blinks the
// cursor every BLINK_FRAMES frames. Without it the cursor is steady.
module text_pixel_pipe #(
  parameter int unsigned COLS         = 80,
  parameter int unsigned ROWS         = 30,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        valid_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [6:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  input  logic [11:0] fg_color,
  input  logic [11:0] bg_color,
  output logic [11:0] char_addr,
  input  logic [7:0]  char_data,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        hsync,
  output logic        vsync
);

  // S1 / S2 pipeline fields
  logic [2:0] s1_x_q, s2_x_q;
  logic [3:0] s1_y_q, s2_y_q;
  logic [6:0] s1_col_q, s2_col_q;
  logic [5:0] s1_row_q, s2_row_q;
  logic       s1_valid_q, s2_valid_q;
  logic       s1_hs_q, s2_hs_q;
  logic       s1_vs_q, s2_vs_q;

  // Output registers
  logic [11:0] rgb_q, rgb_d;
  logic        hsync_q, vsync_q;

  // Cursor latch and frame-edge detect
  logic       vs_prev_q;
  logic       vs_fall;
  logic [6:0] cur_col_q;
  logic [4:0] cur_row_q;
  logic       cur_in_range;
  logic       blink_phase;

  logic       pix;
  logic       cur;

  assign vs_fall = vs_prev_q & ~vsync_in;

  // Addresses are forced to zero during reset so the memories see a quiet bus.
  assign char_addr = reset ? 12'd0
                           : 12'(v_cnt[9:4]) * 12'(COLS) + 12'(h_cnt[9:3]);
  assign font_addr = reset ? 12'd0 : {char_data, s1_y_q};

  always_ff @(posedge pclk) begin
    if (reset) begin
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_col_q   <= '0;
      s1_row_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_hs_q    <= 1'b1;
      s1_vs_q    <= 1'b1;
      s2_x_q     <= '0;
      s2_y_q     <= '0;
      s2_col_q   <= '0;
      s2_row_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_hs_q    <= 1'b1;
      s2_vs_q    <= 1'b1;
      rgb_q      <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
    end else begin
      s1_x_q     <= h_cnt[2:0];
      s1_y_q     <= v_cnt[3:0];
      s1_col_q   <= h_cnt[9:3];
      s1_row_q   <= v_cnt[9:4];
      s1_valid_q <= valid_in;
      s1_hs_q    <= hsync_in;
      s1_vs_q    <= vsync_in;
      s2_x_q     <= s1_x_q;
      s2_y_q     <= s1_y_q;
      s2_col_q   <= s1_col_q;
      s2_row_q   <= s1_row_q;
      s2_valid_q <= s1_valid_q;
      s2_hs_q    <= s1_hs_q;
      s2_vs_q    <= s1_vs_q;
      rgb_q      <= rgb_d;
      hsync_q    <= s2_hs_q;
      vsync_q    <= s2_vs_q;
    end
  end

  // Cursor is sampled once per frame so a mid-frame change cannot tear the cursor.
  always_ff @(posedge pclk) begin
    if (reset) begin
      vs_prev_q <= 1'b1;
      cur_col_q <= '0;
      cur_row_q <= '0;
    end else begin
      vs_prev_q <= vsync_in;
      if (vs_fall) begin
        cur_col_q <= cursor_col;
        cur_row_q <= cursor_row;
      end
    end
  end

`ifdef TEXT_CURSOR_BLINK_EN
  logic [5:0] blink_cnt_q;
  logic       blink_phase_q;

  always_ff @(posedge pclk) begin
    if (reset) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (vs_fall) begin
      if (blink_cnt_q == 6'(BLINK_FRAMES - 1)) begin
        blink_cnt_q   <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 6'd1;
      end
    end
  end

  assign blink_phase = blink_phase_q;
`else
  assign blink_phase = 1'b0;
`endif

  // An off-screen latched cursor (e.g. col = COLS) simply never matches.
  assign cur_in_range = (32'(cur_col_q) < COLS) && (32'(cur_row_q) < ROWS);

  always_comb begin
    pix   = font_data[3'd7 - s2_x_q];
    cur   = ~blink_phase & cur_in_range & (s2_col_q == cur_col_q) &
            (s2_row_q == {1'b0, cur_row_q});
    rgb_d = '0;
    if (s2_valid_q) begin
      rgb_d = (pix ^ cur) ? fg_color : bg_color;
    end
  end

  assign vga_r = rgb_q[11:8];
  assign vga_g = rgb_q[7:4];
  assign vga_b = rgb_q[3:0];
  assign hsync = hsync_q;
  assign vsync = vsync_q;

  // The glyph row is consumed in S1; S2 keeps it only for pipeline symmetry.
  logic unused_s2_y;
  assign unused_s2_y = ^s2_y_q;

endmodule

// File: tb/tb_text_pixel_pipe.sv
module tb_text_pixel_pipe;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int BLINK = 30;

  logic        pclk = 1'b0;
  logic        reset;
  logic [9:0]  h_cnt, v_cnt;
  logic        valid_in, hsync_in, vsync_in;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic [11:0] fg_color, bg_color;
  logic [11:0] char_addr, font_addr;
  logic [7:0]  char_data, font_data;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        hsync, vsync;

  int total = 0;
  int bad   = 0;
  int hs_low_cnt = 0;

  // Expected {rgb[11:0], hsync, vsync}, pushed when inputs are driven.
  logic [13:0] exp_q[$];

  logic [7:0] text_mem[4096];
  logic [7:0] font_mem[4096];

  // Reference state for the per-frame cursor latch
  int   m_col, m_row, falls;
  logic m_prev_vs;

  always #5 pclk = ~pclk;

  // External text RAM and font ROM, 1-cycle read latency
  always @(posedge pclk) begin
    char_data <= text_mem[char_addr];
    font_data <= font_mem[font_addr];
  end

  text_pixel_pipe #(
    .COLS         (COLS),
    .ROWS         (ROWS),
    .BLINK_FRAMES (BLINK)
  ) dut (
    .pclk       (pclk),
    .reset      (reset),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .valid_in   (valid_in),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .fg_color   (fg_color),
    .bg_color   (bg_color),
    .char_addr  (char_addr),
    .char_data  (char_data),
    .font_addr  (font_addr),
    .font_data  (font_data),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .hsync      (hsync),
    .vsync      (vsync)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] model(input logic [9:0] h, input logic [9:0] v,
                                        input logic val, input logic hs, input logic vs);
    int         col, row, addr;
    logic [7:0] code, bits;
    logic [11:0] rgb;
    logic       pix, vis, cur;
    col  = int'(h) / 8;
    row  = int'(v) / 16;
    addr = (row * COLS + col) % 4096;
    code = text_mem[addr];
    bits = font_mem[code * 16 + (int'(v) % 16)];
    pix  = bits[7 - (int'(h) % 8)];
`ifdef TEXT_CURSOR_BLINK_EN
    vis = ((falls / BLINK) % 2) == 0;
`else
    vis = 1'b1;
`endif
    cur = vis && (m_col < COLS) && (m_row < ROWS) && (col == m_col) && (row == m_row);
    rgb = !val ? 12'h000 : ((pix ^ cur) ? fg_color : bg_color);
    return {rgb, hs, vs};
  endfunction

  task automatic drive(input logic [9:0] h, input logic [9:0] v, input logic val,
                       input logic hs, input logic vs);
    reset    = 1'b0;
    h_cnt    = h;
    v_cnt    = v;
    valid_in = val;
    hsync_in = hs;
    vsync_in = vs;
    exp_q.push_back(model(h, v, val, hs, vs));
    if (m_prev_vs && !vs) begin
      m_col = int'(cursor_col);
      m_row = int'(cursor_row);
      falls++;
    end
    m_prev_vs = vs;
  endtask

  task automatic finish_cycle();
    logic [13:0] e;
    @(negedge pclk);
    if (hsync === 1'b0) hs_low_cnt++;
    if (exp_q.size() >= 4) begin
      e = exp_q.pop_front();
      chk("rgb", 32'({vga_r, vga_g, vga_b}), 32'(e[13:2]));
      chk("hsync", 32'(hsync), 32'(e[1]));
      chk("vsync", 32'(vsync), 32'(e[0]));
    end
    @(posedge pclk);
    #1;
  endtask

  task automatic step(input logic [9:0] h, input logic [9:0] v, input logic val,
                      input logic hs, input logic vs);
    drive(h, v, val, hs, vs);
    finish_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic frame();
    idle(3);
    for (int i = 0; i < 3; i++) step(10'd0, 10'd0, 1'b0, 1'b1, 1'b0);
    idle(3);
  endtask

  // Holds reset for n cycles with random inputs; from the first edge on, outputs must be idle.
  task automatic do_reset(input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      reset    = 1'b1;
      h_cnt    = 10'($urandom);
      v_cnt    = 10'($urandom);
      valid_in = 1'($urandom);
      hsync_in = 1'($urandom);
      vsync_in = 1'($urandom);
      #1;
      chk("rst_char_addr", 32'(char_addr), 32'd0);
      chk("rst_font_addr", 32'(font_addr), 32'd0);
      @(negedge pclk);
      if (i > 0) begin
        chk("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
        chk("rst_hsync", 32'(hsync), 32'd1);
        chk("rst_vsync", 32'(vsync), 32'd1);
      end
      @(posedge pclk);
      #1;
    end
    m_col     = 0;
    m_row     = 0;
    falls     = 0;
    m_prev_vs = 1'b1;
    // The three cycles after release still show the cleared pipeline.
    for (int i = 0; i < 3; i++) exp_q.push_back({12'h000, 1'b1, 1'b1});
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      text_mem[i] = 8'h00;
      font_mem[i] = 8'h00;
    end
    text_mem[162]    = 8'h41;  // cell (col 2, row 2)
    font_mem[12'h413] = 8'h80;  // glyph 0x41, row 3: leftmost pixel only
    reset      = 1'b1;
    h_cnt      = '0;
    v_cnt      = '0;
    valid_in   = 1'b0;
    hsync_in   = 1'b1;
    vsync_in   = 1'b1;
    cursor_col = 7'd0;
    cursor_row = 5'd0;
    fg_color   = 12'hF00;
    bg_color   = 12'h00F;
    @(posedge pclk);
    #1;

    // Reset with toggling inputs
    do_reset(3);
    idle(2);

    // Glyph fetch: cell (2,2), glyph row 3
    drive(10'd16, 10'd35, 1'b1, 1'b1, 1'b1);
    #1;
    chk("char_addr", 32'(char_addr), 32'd162);
    finish_cycle();
    drive(10'd17, 10'd35, 1'b1, 1'b1, 1'b1);
    #1;
    chk("font_addr", 32'(font_addr), 32'h413);
    chk("char_addr_x17", 32'(char_addr), 32'd162);
    finish_cycle();
    idle(4);

    // Blanking with an all-ones glyph row
    font_mem[12'h413] = 8'hFF;
    step(10'd16, 10'd35, 1'b0, 1'b1, 1'b1);
    step(10'd17, 10'd35, 1'b0, 1'b1, 1'b1);
    idle(4);
    font_mem[12'h413] = 8'h80;
    idle(1);

    // Horizontal blanking interval with a 96-cycle hsync pulse
    hs_low_cnt = 0;
    for (int h = 640; h < 800; h++) begin
      step(10'(h), 10'd10, 1'b0, !(h >= 656 && h <= 751), 1'b1);
    end
    idle(4);
    chk("hsync_low_len", 32'(hs_low_cnt), 32'd96);

    // Cursor at (2,2) inverts the glyph
    cursor_col = 7'd2;
    cursor_row = 5'd2;
    frame();
    step(10'd16, 10'd35, 1'b1, 1'b1, 1'b1);
    step(10'd17, 10'd35, 1'b1, 1'b1, 1'b1);
    idle(4);

    // Off-screen cursor column: no inversion anywhere
    cursor_col = 7'd80;
    cursor_row = 5'd0;
    frame();
    step(10'd16, 10'd35, 1'b1, 1'b1, 1'b1);
    step(10'd17, 10'd35, 1'b1, 1'b1, 1'b1);
    step(10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
    step(10'd639, 10'd0, 1'b1, 1'b1, 1'b1);
    step(10'd639, 10'd479, 1'b1, 1'b1, 1'b1);
    idle(4);

    // Blink over 60 frames; frame 0 uses the reset cursor (0,0)
    do_reset(3);
    step(10'd1, 10'd0, 1'b1, 1'b1, 1'b1);
    idle(4);
    cursor_col = 7'd2;
    cursor_row = 5'd2;
    for (int f = 1; f <= 60; f++) begin
      frame();
      step(10'd17, 10'd35, 1'b1, 1'b1, 1'b1);
      idle(3);
    end

    // Mid-frame cursor change takes effect on the next frame only
    do_reset(3);
    cursor_col = 7'd2;
    cursor_row = 5'd6;
    frame();
    step(10'd17, 10'd99, 1'b1, 1'b1, 1'b1);
    cursor_col = 7'd5;
    step(10'd17, 10'd100, 1'b1, 1'b1, 1'b1);
    step(10'd41, 10'd100, 1'b1, 1'b1, 1'b1);
    idle(4);
    frame();
    step(10'd17, 10'd100, 1'b1, 1'b1, 1'b1);
    step(10'd41, 10'd100, 1'b1, 1'b1, 1'b1);
    idle(4);

    // Reset mid-line with lit pixels in flight; nothing stale may appear afterwards
    cursor_col = 7'd80;
    frame();
    step(10'd16, 10'd35, 1'b1, 1'b1, 1'b1);
    step(10'd16, 10'd35, 1'b1, 1'b0, 1'b0);
    do_reset(2);
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
